entity_line_scheduler: RTL and testbench
========================================

Name: entity_line_scheduler

Overview:
Per-scanline sprite scheduler placed between the nine entity channels and the frame-buffer colour path. On each line_start pulse it scans all entity descriptors serially and selects up to MAX_SLOTS entities whose tile row matches the current row. It then fetches one 8-pixel sprite row per selected entity from the shared sprite ROM over a req/ack handshake. It presents the resulting per-slot patterns to the colour mixer for the active portion of the line.

Parameters:
NUM_ENTITIES, 9, entity channels scanned; index 0 has the highest priority.
MAX_SLOTS, 4, maximum sprites retained per line.
ENTITY_W, 14, descriptor width: [13:10] ID, [9:8] orientation (bit0 hflip, bit1 vflip), [7:4] tile row, [3:0] tile column.

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high reset
entity_bus  in  NUM_ENTITIES*ENTITY_W  packed descriptors; entity k occupies [k*14 +: 14]
line_start  in  1  one-cycle pulse during hblank that starts scheduling for the next line
tile_row  in  4  tile row of the upcoming line, sampled on line_start
sub_row  in  3  pixel row within the tile, sampled on line_start
rom_req  out  1  sprite ROM read request
rom_addr  out  7  {ID[3:0], effective sub-row[2:0]}
rom_ack  in  1  ROM grant; rom_data is valid in the same cycle
rom_data  in  8  sprite row; bit7 is the leftmost pixel
slot_valid  out  MAX_SLOTS  slot holds a fetched sprite
slot_col  out  MAX_SLOTS*4  tile column per slot
slot_pattern  out  MAX_SLOTS*8  pixel row per slot, with hflip already applied
overflow  out  1  more than MAX_SLOTS entities matched this line
line_ready  out  1  all slots for this line have been fetched
busy  out  1  state is not IDLE and not READY

Behaviour:
- Reset: state=IDLE. rom_req=0, rom_addr=0, slot_valid=0, slot_col=0, slot_pattern=0, overflow=0, line_ready=0, busy=0. Scan index and slot count are cleared.
- States: IDLE, SCAN, FETCH, READY.
  - IDLE/READY -> SCAN on line_start. That cycle: latch tile_row and sub_row, clear slot_valid, overflow, line_ready and slot count, and set scan index to 0.
  - SCAN: one entity per cycle, index 0..NUM_ENTITIES-1. For 9 entities, with line_start in cycle T, the scan occupies T+1..T+9.
    - Match condition: ID != 4'hF and desc[7:4] == latched tile_row.
    - On a match with count < MAX_SLOTS: store ID, orientation and column in slot[count], then increment count.
    - On a match with count == MAX_SLOTS: set overflow=1 and drop the entity.
  - SCAN exit after the last index: go to FETCH if count > 0, otherwise go to READY. With no matches, line_ready=1 from cycle T+10.
  - FETCH: slots are fetched in order 0..count-1.
    - rom_req=1 with rom_addr={ID, vflip ? ~sub_row : sub_row}. rom_req and rom_addr hold stable until rom_ack.
    - On a cycle with rom_req && rom_ack: capture rom_data into slot_pattern[i], bit-reversed if hflip, and set slot_valid[i]=1.
    - In the cycle after an ack, rom_req drops for exactly one cycle before the next slot's request; the first request is asserted in cycle T+10.
    - After the last ack -> READY.
  - READY: line_ready=1. Slot outputs hold until the next line_start.
- line_start while in SCAN or FETCH aborts the current line and restarts SCAN with newly latched values.
  - rom_req deasserts that same cycle, and an ack arriving in that cycle is ignored.
  - Slots are cleared.
- Descriptors are sampled live during SCAN. Upstream holds entity_bus stable from line_start until line_ready.
- reset asserted mid-operation wins over every other event; next cycle is IDLE with all outputs cleared.
- rom_ack while rom_req=0 is ignored.
- slot_col for slot i equals the stored column whenever slot_valid[i]=1. For invalid slots it is 0.

Test Plan:
- Reset, then 3 idle cycles -> all outputs 0, state IDLE, busy=0.
- All IDs = 4'hF, line_start with tile_row=2 -> no rom_req at any point, line_ready=1 at T+10, slot_valid=0000, overflow=0.
- Entity 1 = {4'h3, 2'b00, 8'h25}, entity 6 = {4'h5, 2'b01, 8'h2A}, tile_row=2, sub_row=3, ack tied to 1:
  - first request rom_addr=0x1B, second rom_addr=0x2B;
  - with rom_data=0xC1 for both, slot_pattern[0]=0xC1 and slot_pattern[1]=0x83;
  - slot_col = {0, 0, A, 5}, slot_valid=0011.
- All 9 entities on row 4, IDs 0..8, tile_row=4 -> slots hold IDs 0,1,2,3, overflow=1, exactly 4 ROM transactions.
- vflip entity with ID 7, sub_row=1, ack delayed 5 cycles -> rom_addr=0x3E held stable for all 6 request cycles, then one capture.
- line_start reissued during FETCH (after 1 of 2 acks) -> rom_req drops that cycle, slot_valid clears, scan restarts, and both slots are refetched.
- reset asserted during SCAN -> next cycle all outputs 0 and state IDLE.

Source files
------------

// File: rtl/entity_line_scheduler.sv
// Per-scanline sprite scheduler: scans entity descriptors, picks up to MAX_SLOTS
// on the current tile row, fetches one sprite row each from the shared ROM.
module entity_line_scheduler #(
    parameter int NUM_ENTITIES = 9,
    parameter int MAX_SLOTS    = 4,
    parameter int ENTITY_W     = 14
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_ENTITIES*ENTITY_W-1:0] entity_bus,
    input  logic                             line_start,
    input  logic [3:0]                       tile_row,
    input  logic [2:0]                       sub_row,
    // ROM handshake: a beat completes on any cycle with rom_req && rom_ack; rom_req and
    // rom_addr stay stable until that beat, rom_data is valid alongside rom_ack.
    output logic                             rom_req,
    output logic [6:0]                       rom_addr,
    input  logic                             rom_ack,
    input  logic [7:0]                       rom_data,
    output logic [MAX_SLOTS-1:0]             slot_valid,
    output logic [MAX_SLOTS*4-1:0]           slot_col,
    output logic [MAX_SLOTS*8-1:0]           slot_pattern,
    output logic                             overflow,
    output logic                             line_ready,
    output logic                             busy,
    output logic [1:0]                       dbg_state   // 0 IDLE, 1 SCAN, 2 FETCH, 3 READY
);

    localparam int IDX_W = $clog2(NUM_ENTITIES);
    localparam int CNT_W = $clog2(MAX_SLOTS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTITIES - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_SLOTS);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_FETCH = 2'd2, S_READY = 2'd3} state_t;

    state_t               r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     r_fidx;
    logic [3:0]           r_tile_row;
    logic [2:0]           r_sub_row;
    logic                 r_rom_req;
    logic [6:0]           r_rom_addr;
    logic [MAX_SLOTS-1:0] r_valid;
    logic                 r_overflow;
    logic                 r_line_ready;
    logic [3:0]           r_id      [MAX_SLOTS];
    logic [1:0]           r_orient  [MAX_SLOTS];
    logic [3:0]           r_col     [MAX_SLOTS];
    logic [7:0]           r_pattern [MAX_SLOTS];

    logic [ENTITY_W-1:0]  w_desc;
    logic                 w_match;
    logic                 w_take;
    logic [CNT_W-1:0]     w_cnt_next;
    logic [3:0]           w_f_id;
    logic                 w_f_vflip;
    logic                 w_f_hflip;
    logic [2:0]           w_f_row;
    logic [3:0]           w_s0_id;
    logic [2:0]           w_s0_row;
    logic [7:0]           w_rev;

    always_comb begin
        w_desc = '0;
        for (int k = 0; k < NUM_ENTITIES; k++) begin
            if (r_idx == IDX_W'(k)) w_desc = entity_bus[k*ENTITY_W +: ENTITY_W];
        end
        w_f_id    = '0;
        w_f_vflip = 1'b0;
        w_f_hflip = 1'b0;
        for (int s = 0; s < MAX_SLOTS; s++) begin
            if (r_fidx == CNT_W'(s)) begin
                w_f_id    = r_id[s];
                w_f_vflip = r_orient[s][1];
                w_f_hflip = r_orient[s][0];
            end
        end
        w_rev = '0;
        for (int b = 0; b < 8; b++) w_rev[b] = rom_data[7-b];
    end

    assign w_match    = (r_state == S_SCAN) && (w_desc[13:10] != 4'hF) && (w_desc[7:4] == r_tile_row);
    assign w_take     = w_match && (r_cnt < MAX_CNT);
    assign w_cnt_next = r_cnt + {{(CNT_W-1){1'b0}}, w_take};
    assign w_f_row    = w_f_vflip ? ~r_sub_row : r_sub_row;

    // Slot 0 may be filled by the very last scanned entity, so the first request
    // address bypasses the slot registers to issue on the cycle right after the scan.
    assign w_s0_id  = (r_cnt == '0) ? w_desc[13:10] : r_id[0];
    assign w_s0_row = ((r_cnt == '0) ? w_desc[9] : r_orient[0][1]) ? ~r_sub_row : r_sub_row;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_fidx       <= '0;
            r_tile_row   <= '0;
            r_sub_row    <= '0;
            r_rom_req    <= 1'b0;
            r_rom_addr   <= '0;
            r_valid      <= '0;
            r_overflow   <= 1'b0;
            r_line_ready <= 1'b0;
            for (int s = 0; s < MAX_SLOTS; s++) begin
                r_id[s]      <= '0;
                r_orient[s]  <= '0;
                r_col[s]     <= '0;
                r_pattern[s] <= '0;
            end
        end else if (line_start) begin
            // Also the abort path: any in-flight beat is abandoned and the line restarts.
            r_state      <= S_SCAN;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_fidx       <= '0;
            r_tile_row   <= tile_row;
            r_sub_row    <= sub_row;
            r_rom_req    <= 1'b0;
            r_valid      <= '0;
            r_overflow   <= 1'b0;
            r_line_ready <= 1'b0;
            for (int s = 0; s < MAX_SLOTS; s++) r_pattern[s] <= '0;
        end else begin
            case (r_state)
                S_SCAN: begin
                    if (w_take) begin
                        for (int s = 0; s < MAX_SLOTS; s++) begin
                            if (r_cnt == CNT_W'(s)) begin
                                r_id[s]     <= w_desc[13:10];
                                r_orient[s] <= w_desc[9:8];
                                r_col[s]    <= w_desc[3:0];
                            end
                        end
                        r_cnt <= w_cnt_next;
                    end
                    if (w_match && !w_take) r_overflow <= 1'b1;
                    if (r_idx == LAST_IDX) begin
                        if (w_cnt_next != '0) begin
                            r_state    <= S_FETCH;
                            r_rom_req  <= 1'b1;
                            r_rom_addr <= {w_s0_id, w_s0_row};
                        end else begin
                            r_state      <= S_READY;
                            r_line_ready <= 1'b1;
                        end
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                S_FETCH: begin
                    if (r_rom_req) begin
                        if (rom_ack) begin
                            for (int s = 0; s < MAX_SLOTS; s++) begin
                                if (r_fidx == CNT_W'(s)) begin
                                    r_pattern[s] <= w_f_hflip ? w_rev : rom_data;
                                    r_valid[s]   <= 1'b1;
                                end
                            end
                            r_rom_req <= 1'b0;
                            r_fidx    <= r_fidx + CNT_W'(1);
                            if (r_fidx + CNT_W'(1) == r_cnt) begin
                                r_state      <= S_READY;
                                r_line_ready <= 1'b1;
                            end
                        end
                    end else begin
                        r_rom_req  <= 1'b1;
                        r_rom_addr <= {w_f_id, w_f_row};
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        slot_col     = '0;
        slot_pattern = '0;
        for (int s = 0; s < MAX_SLOTS; s++) begin
            slot_col[s*4 +: 4]     = r_valid[s] ? r_col[s] : 4'h0;
            slot_pattern[s*8 +: 8] = r_pattern[s];
        end
    end

    assign rom_req    = r_rom_req && !line_start;
    assign rom_addr   = r_rom_addr;
    assign slot_valid = r_valid;
    assign overflow   = r_overflow;
    assign line_ready = r_line_ready;
    assign busy       = (r_state == S_SCAN) || (r_state == S_FETCH);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_entity_line_scheduler.sv
// Bench for entity_line_scheduler: directed scenarios plus randomized lines, all checked
// every cycle against a line-level reference model and an expected-address scoreboard.
module tb_entity_line_scheduler;

  localparam int NE = 9;
  localparam int MS = 4;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_SCAN = 2'd1, ST_FETCH = 2'd2, ST_READY = 2'd3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NE*14-1:0] entity_bus = '0;
  logic            line_start = 1'b0;
  logic [3:0]      tile_row = '0;
  logic [2:0]      sub_row = '0;
  logic            rom_req;
  logic [6:0]      rom_addr;
  logic            rom_ack = 1'b0;
  logic [7:0]      rom_data = '0;
  logic [MS-1:0]   slot_valid;
  logic [MS*4-1:0] slot_col;
  logic [MS*8-1:0] slot_pattern;
  logic            overflow, line_ready, busy;
  logic [1:0]      dbg_state;

  entity_line_scheduler dut (
    .clk(clk), .reset(reset), .entity_bus(entity_bus), .line_start(line_start),
    .tile_row(tile_row), .sub_row(sub_row), .rom_req(rom_req), .rom_addr(rom_addr),
    .rom_ack(rom_ack), .rom_data(rom_data), .slot_valid(slot_valid), .slot_col(slot_col),
    .slot_pattern(slot_pattern), .overflow(overflow), .line_ready(line_ready), .busy(busy),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ROM responder: 0 = ack always, 1 = random ack, 2 = ack after ack_delay waiting cycles
  int   ack_mode = 0;
  int   ack_delay = 0;
  int   wcnt = 0;
  logic data_fixed_en = 1'b1;
  logic [7:0] data_fixed = 8'h00;

  always @(posedge clk) begin
    #2;
    case (ack_mode)
      0: rom_ack = 1'b1;
      1: rom_ack = 1'($urandom_range(0, 1));
      default: begin
        if (rom_req) begin
          rom_ack = (wcnt == ack_delay);
          wcnt++;
        end else begin
          rom_ack = 1'b0;
          wcnt = 0;
        end
      end
    endcase
    rom_data = data_fixed_en ? data_fixed : 8'($urandom_range(0, 255));
  end

  // reference model: the whole selection is resolved at line_start from the descriptor table
  logic [1:0] m_st = ST_IDLE;
  logic [3:0] sel_id [MS];
  logic [1:0] sel_or [MS];
  logic [3:0] sel_col [MS];
  int         sel_n = 0, ov_at = -1, m_t = 0, m_next = 0;
  logic [2:0] m_sub = '0;
  logic       e_req = 1'b0, e_over = 1'b0, e_ready = 1'b0;
  logic [6:0] e_addr = '0;
  logic [MS-1:0] e_valid = '0;
  logic [7:0] e_pat [MS];
  logic [6:0] exp_q[$];
  logic [6:0] txn_q[$];
  int         n_req_cycles = 0, n_req_3e = 0;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic [6:0] mk_addr(input int i);
    return {sel_id[i], sel_or[i][1] ? ~m_sub : m_sub};
  endfunction

  always @(negedge clk) begin
    logic [6:0] want;
    if (chk_en) begin
      chk("rom_req", {31'd0, rom_req}, {31'd0, e_req && !line_start});
      if (e_req && !line_start) chk("rom_addr", {25'd0, rom_addr}, {25'd0, e_addr});
      chk("slot_valid", {28'd0, slot_valid}, {28'd0, e_valid});
      for (int s = 0; s < MS; s++) begin
        chk("slot_col", {28'd0, slot_col[s*4 +: 4]}, {28'd0, e_valid[s] ? sel_col[s] : 4'h0});
        if (e_valid[s]) chk("slot_pattern", {24'd0, slot_pattern[s*8 +: 8]}, {24'd0, e_pat[s]});
      end
      chk("overflow", {31'd0, overflow}, {31'd0, e_over});
      chk("line_ready", {31'd0, line_ready}, {31'd0, e_ready});
      chk("busy", {31'd0, busy}, {31'd0, (m_st == ST_SCAN) || (m_st == ST_FETCH)});
      chk("state", {30'd0, dbg_state}, {30'd0, m_st});
      // scoreboard on completed ROM beats
      if (rom_req && rom_ack) begin
        txn_q.push_back(rom_addr);
        chk("sb_pending", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          want = exp_q.pop_front();
          chk("sb_addr", {25'd0, rom_addr}, {25'd0, want});
        end
      end
      if (rom_req) begin
        n_req_cycles++;
        if (rom_addr == 7'h3E) n_req_3e++;
      end
    end
    // model advance using this cycle's inputs
    if (reset) begin
      m_st = ST_IDLE; e_req = 1'b0; e_addr = '0; e_valid = '0; e_over = 1'b0; e_ready = 1'b0;
      exp_q.delete();
    end else if (line_start) begin
      logic [13:0] d;
      m_sub = sub_row; e_valid = '0; e_over = 1'b0; e_ready = 1'b0; e_req = 1'b0;
      m_st = ST_SCAN; m_t = 0; sel_n = 0; ov_at = -1;
      exp_q.delete();
      for (int k = 0; k < NE; k++) begin
        d = entity_bus[k*14 +: 14];
        if (d[13:10] != 4'hF && d[7:4] == tile_row) begin
          if (sel_n < MS) begin
            sel_id[sel_n] = d[13:10]; sel_or[sel_n] = d[9:8]; sel_col[sel_n] = d[3:0];
            sel_n++;
          end else if (ov_at < 0) begin
            ov_at = k;
          end
        end
      end
    end else if (m_st == ST_SCAN) begin
      if (m_t == ov_at) e_over = 1'b1;
      if (m_t == NE - 1) begin
        if (sel_n > 0) begin
          m_st = ST_FETCH; m_next = 0; e_req = 1'b1; e_addr = mk_addr(0);
          for (int i = 0; i < sel_n; i++) exp_q.push_back(mk_addr(i));
        end else begin
          m_st = ST_READY; e_ready = 1'b1;
        end
      end
      m_t++;
    end else if (m_st == ST_FETCH) begin
      if (e_req) begin
        if (rom_ack) begin
          e_pat[m_next] = sel_or[m_next][0] ? rev8(rom_data) : rom_data;
          e_valid[m_next] = 1'b1;
          m_next++;
          e_req = 1'b0;
          if (m_next == sel_n) begin
            m_st = ST_READY; e_ready = 1'b1;
          end
        end
      end else begin
        e_req = 1'b1; e_addr = mk_addr(m_next);
      end
    end
  end

  // driver tasks (all called at posedge + 1)
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_line(input logic [3:0] row, input logic [2:0] sub);
    line_start = 1'b1; tile_row = row; sub_row = sub;
    step(1);
    line_start = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    int k;
    k = 0;
    while (line_ready !== 1'b1 && k < budget) begin
      step(1);
      k++;
    end
    chk("line_ready_timeout", {31'd0, line_ready}, 32'd1);
  endtask

  task automatic set_desc(input int k, input logic [3:0] id, input logic [1:0] ori,
                          input logic [3:0] row, input logic [3:0] col);
    entity_bus[k*14 +: 14] = {id, ori, row, col};
  endtask

  task automatic all_empty();
    for (int k = 0; k < NE; k++) set_desc(k, 4'hF, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, {31'd0, rom_req}, 32'd0);
    chk({tag, "_addr"}, {25'd0, rom_addr}, 32'd0);
    chk({tag, "_valid"}, {28'd0, slot_valid}, 32'd0);
    chk({tag, "_col"}, {16'd0, slot_col}, 32'd0);
    chk({tag, "_pat"}, slot_pattern, 32'd0);
    chk({tag, "_flags"}, {29'd0, overflow, line_ready, busy}, 32'd0);
    chk({tag, "_state"}, {30'd0, dbg_state}, {30'd0, ST_IDLE});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int base_txn, base_req, base_3e, k;
    logic [6:0] exp4 [4];
    // reset, then idle
    step(3);
    reset = 1'b0;
    chk_en = 1'b1;
    step(3);
    chk_all_zero("reset_idle");

    // no live entities
    all_empty();
    base_req = n_req_cycles;
    start_line(4'd2, 3'd0);
    step(8);
    chk("empty_ready_t9", {31'd0, line_ready}, 32'd0);
    step(1);
    chk("empty_ready_t10", {31'd0, line_ready}, 32'd1);
    chk("empty_valid", {28'd0, slot_valid}, 32'd0);
    chk("empty_overflow", {31'd0, overflow}, 32'd0);
    chk("empty_no_req", n_req_cycles - base_req, 32'd0);

    // two matches, one with hflip
    all_empty();
    set_desc(1, 4'h3, 2'b00, 4'h2, 4'h5);
    set_desc(6, 4'h5, 2'b01, 4'h2, 4'hA);
    ack_mode = 0; data_fixed_en = 1'b1; data_fixed = 8'hC1;
    base_txn = txn_q.size();
    start_line(4'd2, 3'd3);
    step(8);
    chk("two_req_t9", {31'd0, rom_req}, 32'd0);
    step(1);
    chk("two_req_t10", {31'd0, rom_req}, 32'd1);
    chk("two_addr0", {25'd0, rom_addr}, 32'h1B);
    wait_ready(50);
    chk("two_ntxn", txn_q.size() - base_txn, 32'd2);
    if (txn_q.size() - base_txn == 2) chk("two_addr1", {25'd0, txn_q[base_txn+1]}, 32'h2B);
    chk("two_pat0", {24'd0, slot_pattern[7:0]}, 32'hC1);
    chk("two_pat1", {24'd0, slot_pattern[15:8]}, 32'h83);
    chk("two_col", {16'd0, slot_col}, 32'h00A5);
    chk("two_valid", {28'd0, slot_valid}, 32'h3);

    // all nine match: first four kept, overflow flagged
    for (int i = 0; i < NE; i++) set_desc(i, 4'(i), 2'b00, 4'h4, 4'(i));
    ack_mode = 1; data_fixed_en = 1'b0;
    base_txn = txn_q.size();
    exp4[0] = 7'h02; exp4[1] = 7'h0A; exp4[2] = 7'h12; exp4[3] = 7'h1A;
    start_line(4'd4, 3'd2);
    wait_ready(300);
    chk("full_overflow", {31'd0, overflow}, 32'd1);
    chk("full_ntxn", txn_q.size() - base_txn, 32'd4);
    if (txn_q.size() - base_txn == 4)
      for (int i = 0; i < 4; i++) chk("full_addr", {25'd0, txn_q[base_txn+i]}, {25'd0, exp4[i]});
    chk("full_col", {16'd0, slot_col}, 32'h3210);
    chk("full_valid", {28'd0, slot_valid}, 32'hF);

    // vflip with a slow ROM
    all_empty();
    set_desc(0, 4'h7, 2'b10, 4'h1, 4'h9);
    ack_mode = 2; ack_delay = 5; data_fixed_en = 1'b1; data_fixed = 8'h3C;
    base_txn = txn_q.size(); base_req = n_req_cycles; base_3e = n_req_3e;
    start_line(4'd1, 3'd1);
    wait_ready(100);
    chk("vflip_req_cycles", n_req_cycles - base_req, 32'd6);
    chk("vflip_addr_held", n_req_3e - base_3e, 32'd6);
    chk("vflip_ntxn", txn_q.size() - base_txn, 32'd1);
    chk("vflip_pat", {24'd0, slot_pattern[7:0]}, 32'h3C);
    chk("vflip_valid", {28'd0, slot_valid}, 32'h1);

    // restart during fetch after the first beat
    all_empty();
    set_desc(1, 4'h3, 2'b00, 4'h2, 4'h5);
    set_desc(6, 4'h5, 2'b01, 4'h2, 4'hA);
    ack_mode = 2; ack_delay = 2; data_fixed = 8'h5A;
    start_line(4'd2, 3'd3);
    k = 0;
    while (!(slot_valid[0] === 1'b1 && rom_req === 1'b1) && k < 100) begin
      step(1);
      k++;
    end
    chk("abort_reach_second_req", {31'd0, slot_valid[0] && rom_req}, 32'd1);
    step(1);
    line_start = 1'b1;
    base_txn = txn_q.size();
    #1;
    chk("abort_req_drop", {31'd0, rom_req}, 32'd0);
    step(1);
    line_start = 1'b0;
    chk("abort_valid_clear", {28'd0, slot_valid}, 32'd0);
    chk("abort_scan", {30'd0, dbg_state}, {30'd0, ST_SCAN});
    wait_ready(100);
    chk("abort_refetch", txn_q.size() - base_txn, 32'd2);
    chk("abort_valid", {28'd0, slot_valid}, 32'h3);

    // reset in the middle of a scan
    for (int i = 0; i < NE; i++) set_desc(i, 4'(i), 2'b11, 4'h4, 4'(i));
    start_line(4'd4, 3'd0);
    step(3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk_all_zero("scan_reset");

    // randomized lines with occasional restarts and resets
    ack_mode = 1; data_fixed_en = 1'b0;
    for (int it = 0; it < 40; it++) begin
      int r;
      for (int i = 0; i < NE; i++)
        set_desc(i, ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14)),
                 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      start_line(4'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
      r = $urandom_range(0, 7);
      if (r == 0) begin
        step($urandom_range(1, 20));
        start_line(4'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
        wait_ready(300);
      end else if (r == 1) begin
        step($urandom_range(1, 15));
        reset = 1'b1;
        step(1);
        reset = 1'b0;
      end else begin
        wait_ready(300);
      end
      step($urandom_range(0, 3));
    end

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
